// File: rtl/full_adder_pkg.sv
// Shared defaults for the registered ripple-carry adder.
// Only the default operand width lives here; the width stays a module parameter.
package full_adder_pkg;
    localparam int FA_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/full_adder_bit.sv
// One ripple-carry cell: purely combinational 1-bit full adder.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);
    logic p;

    assign p  = x ^ y;
    assign s  = p ^ c;
    assign co = (x & y) | (c & p);
endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one cycle of latency.
// The result registers reset synchronously to zero.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int DATA_WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout
);
    logic [DATA_WIDTH:0]   carry;
    logic [DATA_WIDTH-1:0] sum_c;

    assign carry[0] = cin;

    // carry[i] feeds cell i; the last cell's carry becomes cout
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .x  (a[i]),
            .y  (b[i]),
            .c  (carry[i]),
            .s  (sum_c[i]),
            .co (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_c;
            cout <= carry[DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at widths 4 (directed + exhaustive), 1 and 16 (random).
module tb_full_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  a4, b4, s4;
    logic        c4, co4;
    logic [0:0]  a1, b1, s1;
    logic        c1, co1;
    logic [15:0] a16, b16, s16;
    logic        c16, co16;

    logic [4:0]  q4[$];
    logic [1:0]  q1[$];
    logic [16:0] q16[$];

    int total = 0;
    int bad   = 0;

    full_adder #(.DATA_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4), .sum(s4), .cout(co4));
    full_adder #(.DATA_WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .sum(s1), .cout(co1));
    full_adder #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .sum(s16), .cout(co16));

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [16:0] e;
        if (q4.size() == 0) begin
            total++; bad++;
            $error("FAIL %s: w4 scoreboard empty", tag);
        end else begin
            e = 17'(q4.pop_front());
            chk({tag, "_w4"}, 17'({co4, s4}), e);
        end
        if (q1.size() == 0) begin
            total++; bad++;
            $error("FAIL %s: w1 scoreboard empty", tag);
        end else begin
            e = 17'(q1.pop_front());
            chk({tag, "_w1"}, 17'({co1, s1}), e);
        end
        if (q16.size() == 0) begin
            total++; bad++;
            $error("FAIL %s: w16 scoreboard empty", tag);
        end else begin
            e = q16.pop_front();
            chk({tag, "_w16"}, {co16, s16}, e);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected results, clock, compare.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input string tag);
        rst = r;
        a4  = a;  b4  = b;  c4 = c;
        a1  = 1'($urandom);  b1  = 1'($urandom);  c1  = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        q4.push_back(r ? 5'd0 : 5'(a) + 5'(b) + 5'(c));
        q1.push_back(r ? 2'd0 : 2'(a1) + 2'(b1) + 2'(c1));
        q16.push_back(r ? 17'd0 : 17'(a16) + 17'(b16) + 17'(c16));
        @(posedge clk);
        #1;
        pop_chk(tag);
    endtask

    initial begin
        rst = 1'b1;
        a4 = '0; b4 = '0; c4 = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0;
        a16 = '0; b16 = '0; c16 = 1'b0;

        // reset held for two edges
        step(1'b1, 4'b1010, 4'b0110, 1'b1, "reset0");
        step(1'b1, 4'b1111, 4'b1111, 1'b1, "reset1");

        step(1'b0, 4'b1010, 4'b0110, 1'b1, "basic");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, "wrap");
        step(1'b0, 4'b1111, 4'b1111, 1'b1, "max");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "zero");
        step(1'b0, 4'b0011, 4'b0100, 1'b0, "plain");

        // inputs moving between edges must not disturb the registered result
        a4 = 4'b1111; b4 = 4'b1111; c4 = 1'b1;
        #2;
        chk("hold_a", 17'({co4, s4}), 17'h07);
        a4 = 4'b1000; b4 = 4'b1000; c4 = 1'b0;
        #2;
        chk("hold_b", 17'({co4, s4}), 17'h07);

        // reset wins over a result arriving on the same edge
        step(1'b1, 4'b1010, 4'b0110, 1'b1, "rst_prio");
        step(1'b0, 4'b1010, 4'b0110, 1'b1, "after_rst");

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    step(1'b0, 4'(ia), 4'(ib), 1'(ic), "sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
